apb_timer: RTL and testbench
============================

Name: apb_timer

Overview:
- APB3 peripheral slave sitting directly downstream of the AHB-to-APB bridge. It consumes PSEL/PENABLE/PADDR/PWRITE/PWDATA and returns PRDATA/PREADY/PSLVERR.
- Contains a 32-bit prescaled down-counter with auto-reload or one-shot mode and a level interrupt.
- Serves as the first real APB target for bridge bring-up, exercising wait states and error responses.

Parameters:
- ADDRWIDTH, 16: width of PADDR; only PADDR[4:2] is decoded and upper bits are ignored.
- DATAWIDTH, 32: APB data width; only 32 is supported.
- ID_VALUE, 32'h0001_7100: constant returned by the ID register.

Ports:
- PCLK  in  1  APB clock.
- PRESET  in  1  reset; synchronous, active-high.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PADDR  in  ADDRWIDTH  byte address.
- PWRITE  in  1  1 = write.
- PWDATA  in  DATAWIDTH  write data.
- PSTRB  in  4  byte strobes; present only with APB_PSTRB_EN.
- PRDATA  out  DATAWIDTH  read data.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response, valid when PREADY=1.
- TIMERINT  out  1  interrupt, equal to INTSTAT[0] & CTRL.IE.

Behaviour:
- Reset: all registers, prescaler count, read-pending flag and PRDATA are 0. PREADY=0, PSLVERR=0, TIMERINT=0. A reset mid-transfer abandons the transfer; no register is written.
- Register map (offset, access, contents):
  - 0x00 CTRL, RW: [0] EN, [1] IE, [2] ONESHOT, [15:8] PRESCALE; other bits read 0.
  - 0x04 VALUE, RO: current count.
  - 0x08 RELOAD, RW: reload value. A write also loads VALUE on the same edge.
  - 0x0C INTSTAT, W1C: bit [0].
  - 0x10 ID, RO: ID_VALUE.
- Write handshake:
  - PREADY=1 in the first access cycle (PSEL & PENABLE & PWRITE). The register updates at that edge, so there are zero wait states.
- Read handshake: exactly one wait state.
  - First access cycle: PREADY=0 and the addressed data is captured into PRDATA.
  - Second access cycle: PREADY=1 with PRDATA valid.
  - The read-pending flag clears when PREADY=1.
  - PRDATA returns 0 whenever PREADY=0.
- PREADY is 0 outside access phases.
- PSLVERR=1 (with PREADY=1) for:
  - any offset above 0x10;
  - a write to VALUE or ID.
  - Such writes have no effect, and erroneous reads return 0.
- Prescaler: an 8-bit count runs while EN=1. It generates one tick every PRESCALE+1 cycles (PRESCALE=0 ticks every cycle). It is cleared when EN=0 and on a 0->1 write of EN.
- On a tick:
  - VALUE!=0: VALUE decrements by 1.
  - VALUE==0: INTSTAT[0] is set.
    - ONESHOT=1: EN clears and VALUE holds 0.
    - ONESHOT=0: VALUE loads RELOAD.
- Simultaneous events, same cycle:
  - Tick-set and W1C of INTSTAT: set wins.
  - RELOAD write and tick: the written value wins, loaded directly into VALUE without decrementing.
  - CTRL write clearing EN and a tick at VALUE==0: the interrupt still sets.
- Counter wrap: VALUE never underflows past 0.

Optional Feature:
- Macro: APB_PSTRB_EN.
- Defined: the PSTRB port exists. Writable register bytes update only where PSTRB[n]=1. For INTSTAT, W1C applies only when PSTRB[0]=1. A write with PSTRB=0 completes with PREADY=1, PSLVERR=0 and no effect.
- Undefined: no PSTRB port; all writes are full-word.

Decomposition:
- Package apb_timer_pkg holds:
  - register offset constants (CTRL/VALUE/RELOAD/INTSTAT/ID);
  - CTRL bit-position constants;
  - the default ID constant;
  - a register-select enum.
- Sub-module apb_timer_core holds the prescaler, down-counter, reload/one-shot logic and INTSTAT set pulse. The top level keeps the APB decode, handshake and register storage.

Test Plan:
- Reset then read ID: PREADY=0 in access cycle 1 and 1 in cycle 2; PRDATA=32'h0001_7100; PSLVERR=0.
- Write RELOAD=5, CTRL=0x3 (EN, IE, PRESCALE=0): VALUE reads 4,3,… and hits 0 after 5 ticks. Next tick: TIMERINT=1 and VALUE=5. Writing INTSTAT=1 drops TIMERINT next cycle.
- CTRL=0x0205 (EN, ONESHOT, PRESCALE=2) with RELOAD=2: ticks every 3 cycles. Interrupt sets about 9 cycles after enable; EN then reads 0 and VALUE stays 0.
- Write to VALUE, and read at offset 0x14: PREADY=1, PSLVERR=1, VALUE unchanged, PRDATA=0.
- Force an INTSTAT W1C write in the same cycle as the tick at VALUE==0: INTSTAT stays 1.
- APB_PSTRB_EN: write RELOAD=0xAABBCCDD with PSTRB=4'b0101 over RELOAD=0 -> RELOAD reads 0x00BB00DD.

Source files
------------

// File: rtl/apb_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb_timer_pkg
//  Brief    : Register offsets, CTRL field positions, ID default and the
//             register-select decode shared by the APB timer files.
//  Revision : 1.0 - initial release
// ============================================================================
package apb_timer_pkg;

    // Byte offsets of the register map (only PADDR[4:2] is decoded)
    localparam logic [4:0] c_OFF_CTRL    = 5'h00;
    localparam logic [4:0] c_OFF_VALUE   = 5'h04;
    localparam logic [4:0] c_OFF_RELOAD  = 5'h08;
    localparam logic [4:0] c_OFF_INTSTAT = 5'h0C;
    localparam logic [4:0] c_OFF_ID      = 5'h10;

    // CTRL field positions
    localparam int c_CTRL_EN         = 0;
    localparam int c_CTRL_IE         = 1;
    localparam int c_CTRL_ONESHOT    = 2;
    localparam int c_CTRL_PRESC_LSB  = 8;
    localparam int c_CTRL_PRESC_MSB  = 15;

    localparam logic [31:0] c_ID_DEFAULT = 32'h0001_7100;

    typedef enum logic [2:0] {
        SEL_NONE    = 3'd0,
        SEL_CTRL    = 3'd1,
        SEL_VALUE   = 3'd2,
        SEL_RELOAD  = 3'd3,
        SEL_INTSTAT = 3'd4,
        SEL_ID      = 3'd5
    } reg_sel_e;

    function automatic reg_sel_e decode_sel(input logic [4:0] off);
        reg_sel_e sel;
        case (off)
            c_OFF_CTRL:    sel = SEL_CTRL;
            c_OFF_VALUE:   sel = SEL_VALUE;
            c_OFF_RELOAD:  sel = SEL_RELOAD;
            c_OFF_INTSTAT: sel = SEL_INTSTAT;
            c_OFF_ID:      sel = SEL_ID;
            default:       sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage : apb_timer_pkg
`default_nettype wire

// File: rtl/apb_timer_core.sv
`default_nettype none
// ============================================================================
//  Module   : apb_timer_core
//  Brief    : Prescaler, 32-bit down-counter with reload / one-shot handling
//             and the interrupt-set pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_timer_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [7:0]  i_prescale,
    input  logic        i_oneshot,
    input  logic [31:0] i_reload,
    input  logic        i_load,
    input  logic [31:0] i_load_value,
    input  logic        i_presc_clr,
    output logic [31:0] o_value,
    output logic        o_int_set,
    output logic        o_oneshot_stop
);

    logic [7:0]  r_presc;
    logic [31:0] r_value;
    logic        w_tick;
    logic        w_zero;

    assign w_tick = i_en & (r_presc == i_prescale);
    assign w_zero = (r_value == 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_value <= '0;
        end else begin
            if (!i_en || i_presc_clr || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 8'd1;
            end

            // A software load beats the tick; in one-shot mode VALUE parks at 0
            if (i_load) begin
                r_value <= i_load_value;
            end else if (w_tick) begin
                if (!w_zero) begin
                    r_value <= r_value - 32'd1;
                end else if (!i_oneshot) begin
                    r_value <= i_reload;
                end
            end
        end
    end

    assign o_value        = r_value;
    assign o_int_set      = w_tick & w_zero;
    assign o_oneshot_stop = w_tick & w_zero & i_oneshot;

endmodule : apb_timer_core
`default_nettype wire

// File: rtl/apb_timer.sv
`default_nettype none
// ============================================================================
//  Module   : apb_timer
//  Brief    : APB3 timer slave: decode, zero-wait writes, one-wait reads,
//             register storage and level interrupt.
//             Optional macro APB_PSTRB_EN adds the PSTRB byte-strobe port.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter int          ADDRWIDTH = 16,
    parameter int          DATAWIDTH = 32,
    parameter logic [31:0] ID_VALUE  = c_ID_DEFAULT
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic [ADDRWIDTH-1:0] PADDR,
    input  logic                 PWRITE,
    input  logic [DATAWIDTH-1:0] PWDATA,
`ifdef APB_PSTRB_EN
    input  logic [3:0]           PSTRB,
`endif
    output logic [DATAWIDTH-1:0] PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output logic                 TIMERINT
);

    logic        r_en;
    logic        r_ie;
    logic        r_oneshot;
    logic [7:0]  r_prescale;
    logic [31:0] r_reload;
    logic        r_intstat;
    logic        r_rd_pend;
    logic [31:0] r_prdata;

    reg_sel_e    w_sel;
    logic [3:0]  w_strb;
    logic        w_access;
    logic        w_wr;
    logic        w_rd;
    logic        w_rd_first;
    logic        w_rd_done;
    logic        w_err;
    logic        w_wr_ok;
    logic        w_wr_ctrl;
    logic        w_wr_reload;
    logic        w_wr_intstat;
    logic        w_reload_load;
    logic        w_en_rise;
    logic [31:0] w_reload_next;
    logic [31:0] w_rd_data;
    logic [31:0] w_value;
    logic        w_int_set;
    logic        w_oneshot_stop;
    logic        w_unused;

    assign w_unused = ^{PADDR[ADDRWIDTH-1:5], PADDR[1:0]};

`ifdef APB_PSTRB_EN
    assign w_strb = PSTRB;
`else
    assign w_strb = 4'hF;
`endif

    assign w_sel      = decode_sel({PADDR[4:2], 2'b00});
    assign w_access   = PSEL & PENABLE & ~PRESET;
    assign w_wr       = w_access & PWRITE;
    assign w_rd       = w_access & ~PWRITE;
    assign w_rd_first = w_rd & ~r_rd_pend;
    assign w_rd_done  = w_rd & r_rd_pend;

    // VALUE and ID are read-only, so writing them is an error as well
    assign w_err = (w_sel == SEL_NONE) |
                   (PWRITE & ((w_sel == SEL_VALUE) | (w_sel == SEL_ID)));

    assign w_wr_ok      = w_wr & ~w_err;
    assign w_wr_ctrl    = w_wr_ok & (w_sel == SEL_CTRL);
    assign w_wr_reload  = w_wr_ok & (w_sel == SEL_RELOAD);
    assign w_wr_intstat = w_wr_ok & (w_sel == SEL_INTSTAT);

    assign w_reload_load = w_wr_reload & (|w_strb);
    assign w_en_rise     = w_wr_ctrl & w_strb[0] & PWDATA[c_CTRL_EN] & ~r_en;

    generate
        for (genvar b = 0; b < 4; b++) begin : g_reload_byte
            assign w_reload_next[8*b +: 8] = w_strb[b] ? PWDATA[8*b +: 8]
                                                       : r_reload[8*b +: 8];
        end
    endgenerate

    always_comb begin
        w_rd_data = '0;
        case (w_sel)
            SEL_CTRL: begin
                w_rd_data[c_CTRL_EN]                          = r_en;
                w_rd_data[c_CTRL_IE]                          = r_ie;
                w_rd_data[c_CTRL_ONESHOT]                     = r_oneshot;
                w_rd_data[c_CTRL_PRESC_MSB:c_CTRL_PRESC_LSB]  = r_prescale;
            end
            SEL_VALUE:   w_rd_data = w_value;
            SEL_RELOAD:  w_rd_data = r_reload;
            SEL_INTSTAT: w_rd_data = {31'd0, r_intstat};
            SEL_ID:      w_rd_data = ID_VALUE;
            default:     w_rd_data = '0;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_en       <= 1'b0;
            r_ie       <= 1'b0;
            r_oneshot  <= 1'b0;
            r_prescale <= '0;
            r_reload   <= '0;
            r_intstat  <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_prdata   <= '0;
        end else begin
            if (w_wr_ctrl && w_strb[0]) begin
                r_en      <= PWDATA[c_CTRL_EN];
                r_ie      <= PWDATA[c_CTRL_IE];
                r_oneshot <= PWDATA[c_CTRL_ONESHOT];
            end else if (w_oneshot_stop) begin
                r_en <= 1'b0;
            end

            if (w_wr_ctrl && w_strb[1]) begin
                r_prescale <= PWDATA[c_CTRL_PRESC_MSB:c_CTRL_PRESC_LSB];
            end

            if (w_reload_load) begin
                r_reload <= w_reload_next;
            end

            // Hardware set outranks a same-cycle software clear
            if (w_int_set) begin
                r_intstat <= 1'b1;
            end else if (w_wr_intstat && w_strb[0] && PWDATA[0]) begin
                r_intstat <= 1'b0;
            end

            r_rd_pend <= w_rd_first;
            if (w_rd_first) begin
                r_prdata <= w_rd_data;
            end
        end
    end

    apb_timer_core u_core (
        .clk            (PCLK),
        .rst            (PRESET),
        .i_en           (r_en),
        .i_prescale     (r_prescale),
        .i_oneshot      (r_oneshot),
        .i_reload       (r_reload),
        .i_load         (w_reload_load),
        .i_load_value   (w_reload_next),
        .i_presc_clr    (w_en_rise),
        .o_value        (w_value),
        .o_int_set      (w_int_set),
        .o_oneshot_stop (w_oneshot_stop)
    );

    assign PREADY   = w_wr | w_rd_done;
    assign PSLVERR  = (w_wr | w_rd_done) & w_err;
    assign PRDATA   = w_rd_done ? r_prdata : '0;
    assign TIMERINT = r_intstat & r_ie;

endmodule : apb_timer
`default_nettype wire

// File: tb/tb_apb_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_timer
//  Brief    : Self-checking bench for apb_timer: directed and random APB
//             traffic against a cycle-level reference model with scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_timer;

    logic        PCLK    = 1'b0;
    logic        PRESET  = 1'b1;
    logic        PSEL    = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE  = 1'b0;
    logic [15:0] PADDR   = '0;
    logic [31:0] PWDATA  = '0;
    logic [3:0]  PSTRB   = 4'hF;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        TIMERINT;

    int n_checks = 0;
    int n_fail   = 0;

    apb_timer dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
`ifdef APB_PSTRB_EN
        .PSTRB    (PSTRB),
`endif
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .TIMERINT (TIMERINT)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit is_read;
        bit err;
        int waits;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rd_q[$];

    bit          m_en = 0, m_ie = 0, m_os = 0, m_int = 0, m_pend = 0;
    int          m_ps = 0;
    int          m_k  = 0;
    logic [31:0] m_reload = '0;
    logic [31:0] m_value  = '0;

    function automatic logic [31:0] m_read(input int idx);
        logic [7:0] ps8;
        ps8 = m_ps[7:0];
        case (idx)
            0:       return {16'h0, ps8, 5'h0, m_os, m_ie, m_en};
            1:       return m_value;
            2:       return m_reload;
            3:       return {31'h0, m_int};
            4:       return 32'h0001_7100;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge PCLK) begin
        int          idx;
        bit          acc, wr, tick, fire, old_en;
        logic [3:0]  strb;
        logic [31:0] merged;
        if (PRESET) begin
            m_en = 0; m_ie = 0; m_os = 0; m_int = 0; m_pend = 0;
            m_ps = 0; m_k = 0; m_reload = '0; m_value = '0;
            rd_q.delete();
        end else begin
`ifdef APB_PSTRB_EN
            strb = PSTRB;
`else
            strb = 4'hF;
`endif
            idx    = int'(PADDR[4:2]);
            acc    = PSEL && PENABLE;
            wr     = acc && PWRITE;
            tick   = m_en && ((m_k % (m_ps + 1)) == m_ps);
            fire   = tick && (m_value == 0);
            old_en = m_en;

            if (acc && !PWRITE && !m_pend) rd_q.push_back(m_read(idx));
            m_pend = acc && !PWRITE && !m_pend;

            if (wr && idx == 2 && strb != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    merged[8*b +: 8] = strb[b] ? PWDATA[8*b +: 8] : m_reload[8*b +: 8];
                m_reload = merged;
                m_value  = merged;
            end else if (tick) begin
                if (m_value != 0) m_value = m_value - 1;
                else if (!m_os)   m_value = m_reload;
            end

            if (fire) m_int = 1;
            else if (wr && idx == 3 && strb[0] && PWDATA[0]) m_int = 0;

            if (wr && idx == 0 && strb[0]) begin
                m_en = PWDATA[0];
                m_ie = PWDATA[1];
                m_os = PWDATA[2];
            end else if (fire && m_os) begin
                m_en = 0;
            end
            if (wr && idx == 0 && strb[1]) m_ps = int'(PWDATA[15:8]);

            m_k = (old_en && m_en) ? m_k + 1 : 0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int mon_waits = 0;

    always @(negedge PCLK) begin
        exp_t e;
        if (PRESET) begin
            chk("pready_in_reset", {31'h0, PREADY}, 32'h0);
            mon_waits = 0;
        end else begin
            chk("timerint", {31'h0, TIMERINT}, {31'h0, m_int & m_ie});
            if (PSEL && PENABLE) begin
                if (PREADY) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ready", 32'h1, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wait_states", mon_waits, e.waits);
                        chk("pslverr", {31'h0, PSLVERR}, {31'h0, e.err});
                        if (e.is_read) begin
                            if (rd_q.size() == 0) chk("read_data_missing", 32'h1, 32'h0);
                            else chk("prdata", PRDATA, rd_q.pop_front());
                        end
                    end
                    mon_waits = 0;
                end else begin
                    chk("prdata_while_wait", PRDATA, 32'h0);
                    mon_waits++;
                end
            end else begin
                chk("pready_idle", {31'h0, PREADY}, 32'h0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic apb(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
        exp_t e;
        bit   done;
        int   idx;
        idx     = int'(addr[4:2]);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = data;
        PSTRB   = strb;
        @(posedge PCLK); #1;
        PENABLE   = 1'b1;
        e.is_read = !wr;
        e.err     = (idx > 4) || (wr && (idx == 1 || idx == 4));
        e.waits   = wr ? 0 : 1;
        exp_q.push_back(e);
        done = 0;
        for (int i = 0; i < 6 && !done; i++) begin
            @(negedge PCLK);
            done = PREADY;
            @(posedge PCLK); #1;
        end
        if (!done) begin
            chk("apb_timeout", 32'h0, 32'h1);
            exp_q.delete();
        end
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic wr32(input logic [15:0] addr, input logic [31:0] data);
        apb(1'b1, addr, data, 4'hF);
    endtask

    task automatic rd32(input logic [15:0] addr);
        apb(1'b0, addr, 32'h0, 4'hF);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          op, ps, sel;
        logic [15:0] addr;
        logic [3:0]  rs;

        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        chk("reset_prdata", PRDATA, 32'h0);
        chk("reset_pslverr", {31'h0, PSLVERR}, 32'h0);
        chk("reset_timerint", {31'h0, TIMERINT}, 32'h0);
        @(posedge PCLK); #1;

        for (int i = 0; i < 5; i++) rd32(16'(i * 4));   // reset values incl. ID

        // periodic count with interrupt
        wr32(16'h0008, 32'd5);
        wr32(16'h0000, 32'h3);
        for (int i = 0; i < 4; i++) rd32(16'h0004);
        idle(4);
        rd32(16'h000C);
        wr32(16'h000C, 32'h1);
        idle(2);
        wr32(16'h0000, 32'h0);
        wr32(16'h000C, 32'h1);

        // one-shot with prescale 2
        wr32(16'h0008, 32'd2);
        wr32(16'h0000, 32'h0205);
        idle(12);
        rd32(16'h0000);
        rd32(16'h0004);
        rd32(16'h000C);
        wr32(16'h000C, 32'h1);

        // error responses
        wr32(16'h0004, 32'h1234);
        wr32(16'h0010, 32'hFFFF);
        rd32(16'h0014);
        wr32(16'h001C, 32'h7);
        rd32(16'h0004);

        // W1C collides with tick-at-zero every cycle while RELOAD=0
        wr32(16'h0008, 32'd0);
        wr32(16'h0000, 32'h3);
        idle(2);
        wr32(16'h000C, 32'h1);
        rd32(16'h000C);
        wr32(16'h0000, 32'h0);
        wr32(16'h000C, 32'h1);

`ifdef APB_PSTRB_EN
        wr32(16'h0008, 32'h0);
        apb(1'b1, 16'h0008, 32'hAABBCCDD, 4'b0101);
        rd32(16'h0008);
        apb(1'b1, 16'h0008, 32'h12345678, 4'b0000);
        rd32(16'h0008);
`endif

        // reset in the middle of a RELOAD write
        wr32(16'h0008, 32'd7);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = 16'h0008; PWDATA = 32'h55; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        PRESET  = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PRESET = 1'b0;
        rd32(16'h0008);
        rd32(16'h0000);

        // random traffic, prescale fixed within each segment
        for (int seg = 0; seg < 4; seg++) begin
            ps = $urandom_range(0, 3);
            wr32(16'h0000, {16'h0, 8'(ps), 8'h0});
            for (int n = 0; n < 60; n++) begin
                op   = $urandom_range(0, 7);
                addr = 16'($urandom);
                case (op)
                    0, 1, 2: rd32({addr[15:5], 3'($urandom_range(0, 7)), addr[1:0]});
                    3: begin
                        rs = 4'hF;
`ifdef APB_PSTRB_EN
                        rs = 4'($urandom);
`endif
                        apb(1'b1, {addr[15:5], 3'd2, addr[1:0]}, 32'($urandom_range(0, 12)), rs);
                    end
                    4: wr32({addr[15:5], 3'd0, addr[1:0]},
                            {16'h0, 8'(ps), 5'h0, 3'($urandom)});
                    5: wr32({addr[15:5], 3'd3, addr[1:0]}, 32'($urandom_range(0, 1)));
                    6: begin
                        sel = $urandom_range(0, 4);
                        sel = (sel == 0) ? 1 : (sel == 1) ? 4 : sel + 3;
                        wr32({addr[15:5], 3'(sel), addr[1:0]}, 32'($urandom));
                    end
                    default: idle($urandom_range(0, 5));
                endcase
            end
        end

        idle(3);
        chk("scoreboard_empty", exp_q.size(), 32'h0);
        chk("read_queue_empty", rd_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_apb_timer
`default_nettype wire
